// File: rtl/clk_div_n.sv
// -----------------------------------------------------------------------------
// clk_div_n -- runtime-programmable integer clock divider (N >= 2)
//
// Divides clk by N and produces a registered divided clock plus a one-cycle
// strobe on the clk edge where the divided clock rises. New divisors are held
// as "pending" and only take effect on a period boundary, so the output never
// produces truncated or runt pulses.
//
// Parameters
//   WIDTH        bit width of divisor and counter (N max = 2**WIDTH-1)
//   DEFAULT_DIV  divisor in effect after reset (2 .. 2**WIDTH-1)
//
// Ports
//   clk         in   system clock
//   reset       in   asynchronous reset, active low
//   en          in   divider enable; 0 freezes the counter and forces clk_out low
//   div_val     in   requested divisor N
//   div_load    in   1-cycle strobe capturing div_val as the pending divisor
//   clk_out     out  divided clock
//   tick        out  1-cycle pulse at the start of each divided period
//   div_active  out  divisor currently in effect
//   div_err     out  sticky flag: a load with div_val < 2 was rejected
//
// Build option
//   DUTY_50_EN  when defined, a negedge flop stretches the high phase by half a
//               clk period for odd N, giving exactly 50% duty. Even N and tick
//               timing are unchanged. Undefined by default (posedge-only).
// -----------------------------------------------------------------------------
module clk_div_n #(
   parameter int WIDTH       = 8,
   parameter int DEFAULT_DIV = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] div_val,
   input  logic             div_load,
   output logic             clk_out,
   output logic             tick,
   output logic [WIDTH-1:0] div_active,
   output logic             div_err
);

   localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
   localparam logic [WIDTH-1:0] MIN_DIV = WIDTH'(2);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] div_active_q, div_active_d;
   logic [WIDTH-1:0] pend_q, pend_d;
   logic             pend_vld_q, pend_vld_d;
   logic             restart_q, restart_d;    // en was low: next enabled edge starts a period
   logic             hi_pos_q, hi_pos_d;
   logic             tick_q, tick_d;
   logic             div_err_q, div_err_d;

   logic             wrap;
   logic             period_start;
   logic [WIDTH-1:0] n_eff;

   assign wrap         = (cnt_q == div_active_q - ONE);
   assign period_start = en && (restart_q || wrap);
   // A pending divisor is applied first, so the new period already runs with it.
   assign n_eff        = (period_start && pend_vld_q) ? pend_q : div_active_q;

   // NOTE: every variable gets a default at the top of the block; any path
   // that skipped an assignment would otherwise infer a latch.
   always_comb begin
      cnt_d        = cnt_q;
      div_active_d = div_active_q;
      pend_d       = pend_q;
      pend_vld_d   = pend_vld_q;
      restart_d    = restart_q;
      hi_pos_d     = 1'b0;
      tick_d       = 1'b0;
      div_err_d    = div_err_q;

      if (en) begin
         restart_d = 1'b0;
         if (period_start) begin
            cnt_d        = '0;
            div_active_d = n_eff;
            pend_vld_d   = 1'b0;
         end else begin
            cnt_d = cnt_q + ONE;
         end
         hi_pos_d = (cnt_d < (n_eff >> 1));
         tick_d   = period_start;
      end else begin
         restart_d = 1'b1;
      end

      // Evaluated after the apply step: a load on the wrap edge itself
      // re-arms pending and lands at the following boundary.
      if (div_load) begin
         if (div_val >= MIN_DIV) begin
            pend_d     = div_val;
            pend_vld_d = 1'b1;
            div_err_d  = 1'b0;
         end else begin
            div_err_d  = 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop
   // samples the pre-edge values regardless of statement order.
   // NOTE: all state here is plain control registers and each one is reset;
   // the counter preset to DEFAULT_DIV-1 makes the first enabled edge a wrap.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q        <= DEF_DIV - ONE;
         div_active_q <= DEF_DIV;
         pend_q       <= '0;
         pend_vld_q   <= 1'b0;
         restart_q    <= 1'b0;
         hi_pos_q     <= 1'b0;
         tick_q       <= 1'b0;
         div_err_q    <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         div_active_q <= div_active_d;
         pend_q       <= pend_d;
         pend_vld_q   <= pend_vld_d;
         restart_q    <= restart_d;
         hi_pos_q     <= hi_pos_d;
         tick_q       <= tick_d;
         div_err_q    <= div_err_d;
      end
   end

`ifdef DUTY_50_EN
   // Half-cycle-delayed copy of the high phase, only for odd N; OR-ing it in
   // extends the high time to exactly N/2 clk periods.
   logic hi_neg_q;

   always_ff @(negedge clk or negedge reset) begin
      if (!reset) begin
         hi_neg_q <= 1'b0;
      end else begin
         hi_neg_q <= hi_pos_q & div_active_q[0];
      end
   end

   assign clk_out = hi_pos_q | hi_neg_q;
`else
   assign clk_out = hi_pos_q;
`endif

   assign tick       = tick_q;
   assign div_active = div_active_q;
   assign div_err    = div_err_q;

endmodule

// File: tb/tb_clk_div_n.sv
// -----------------------------------------------------------------------------
// tb_clk_div_n -- self-checking bench for clk_div_n
//
// Inputs change on the falling edge. A reference model, kept as "position in
// the current period" plus divisor bookkeeping, advances on each rising edge
// and the DUT outputs are compared 2 ns later on every cycle. Directed
// scenarios pin the model with literal expectations, then a randomized phase
// exercises enables, loads, illegal loads and resets.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_clk_div_n;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst_n;
   logic             en;
   logic [WIDTH-1:0] div_val;
   logic             div_load;
   logic             clk_out;
   logic             tick;
   logic [WIDTH-1:0] div_active;
   logic             div_err;

   int checks;
   int errors;
   int tick_cnt;

   clk_div_n #(.WIDTH(WIDTH), .DEFAULT_DIV(3)) dut (
      .clk        (clk),
      .reset      (rst_n),
      .en         (en),
      .div_val    (div_val),
      .div_load   (div_load),
      .clk_out    (clk_out),
      .tick       (tick),
      .div_active (div_active),
      .div_err    (div_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int m_n;          // divisor in effect
   int m_pend;       // pending divisor value
   bit m_pend_vld;
   int m_pos;        // cycles elapsed in the current period (0 = first)
   bit m_restart;    // next enabled edge starts a new period
   bit m_err;
   bit m_out;        // posedge high term
   bit m_neg;        // half-cycle-delayed high term (odd N only)
   bit m_tick;
   bit start;

   initial begin
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            m_n = 3; m_pend = 0; m_pend_vld = 0; m_pos = 0;
            m_restart = 1; m_err = 0; m_out = 0; m_neg = 0; m_tick = 0;
         end else begin
            // value the falling edge before this rising edge captured
            m_neg = m_out && (m_n % 2 == 1);
            if (en) begin
               start = m_restart || (m_pos + 1 == m_n);
               if (start) begin
                  if (m_pend_vld) begin
                     m_n = m_pend;
                     m_pend_vld = 0;
                  end
                  m_pos = 0;
               end else begin
                  m_pos++;
               end
               m_restart = 0;
               m_out  = (m_pos < m_n / 2);
               m_tick = start;
            end else begin
               m_restart = 1;
               m_out = 0;
               m_tick = 0;
            end
            if (div_load) begin
               if (int'(div_val) >= 2) begin
                  m_pend = int'(div_val);
                  m_pend_vld = 1;
                  m_err = 0;
               end else begin
                  m_err = 1;
               end
            end
         end
         #2;
`ifdef DUTY_50_EN
         check("clk_out", int'(clk_out), int'(m_out | m_neg));
`else
         check("clk_out", int'(clk_out), int'(m_out));
`endif
         check("tick", int'(tick), int'(m_tick));
         check("div_active", int'(div_active), m_n);
         check("div_err", int'(div_err), int'(m_err));
         if (tick) tick_cnt++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic load(input int v);
      div_val  = WIDTH'(v);
      div_load = 1'b1;
      @(negedge clk);
      div_load = 1'b0;
   endtask

   // Count ticks over n cycles; alignment-independent when n is a multiple of N.
   task automatic tick_window(input string name, input int n, input int exp);
      tick_cnt = 0;
      cycles(n);
      check(name, tick_cnt, exp);
   endtask

   int r;

   initial begin
      checks = 0; errors = 0; tick_cnt = 0;
      rst_n = 1'b0; en = 1'b0; div_val = '0; div_load = 1'b0;

      // 1: reset state, first period, default N=3
      cycles(2);
      check("rst_clk_out", int'(clk_out), 0);
      check("rst_tick", int'(tick), 0);
      check("rst_div_active", int'(div_active), 3);
      check("rst_div_err", int'(div_err), 0);
      rst_n = 1'b1; en = 1'b1;
      @(posedge clk); #2;
      check("first_clk_out", int'(clk_out), 1);
      check("first_tick", int'(tick), 1);
      @(negedge clk);
      tick_window("ticks_n3", 30, 10);

      // 2: load 4 mid-period
      load(4);
      cycles(6);
      check("n4_active", int'(div_active), 4);
      tick_window("ticks_n4", 40, 10);

      // 3: two loads in one period, last wins
      load(5);
      load(6);
      cycles(12);
      check("n6_active", int'(div_active), 6);
      tick_window("ticks_n6", 60, 10);

      // 4: illegal load sets sticky error, legal load clears it
      load(1);
      check("err_set", int'(div_err), 1);
      cycles(8);
      check("err_keep_n", int'(div_active), 6);
      load(2);
      check("err_clr", int'(div_err), 0);
      cycles(6);
      tick_window("ticks_n2", 20, 10);

      // 5: enable low freezes, re-enable restarts a period
      en = 1'b0;
      cycles(5);
      check("dis_clk_out", int'(clk_out), 0);
      check("dis_tick", int'(tick), 0);
      en = 1'b1;
      @(posedge clk); #2;
      check("reen_clk_out", int'(clk_out), 1);
      check("reen_tick", int'(tick), 1);
      @(negedge clk);

      // 6: async reset mid-period drops the pending load
      load(7);
      cycles(1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_clk_out", int'(clk_out), 0);
      check("mid_rst_active", int'(div_active), 3);
      @(negedge clk);
      rst_n = 1'b1;
      cycles(9);
      check("post_rst_active", int'(div_active), 3);
      tick_window("ticks_post_rst", 30, 10);

      // randomized phase
      for (int i = 0; i < 4000; i++) begin
         en       = ($urandom_range(0, 9) != 0);
         rst_n    = ($urandom_range(0, 399) != 0);
         div_load = ($urandom_range(0, 7) == 0);
         r        = int'($urandom_range(0, 19));
         div_val  = (r == 0) ? 8'hFF : WIDTH'(r);
         @(negedge clk);
      end
      div_load = 1'b0;
      cycles(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
